// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 modified Booth multiplier: one Booth digit retired per clock,
// start/busy/done handshake. Define BOOTH_UNSIGNED_EN to add the tc (signed/unsigned) input.

module booth_r4_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               tc,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int AW = WIDTH + 2;
`ifdef BOOTH_UNSIGNED_EN
  // Two spare multiplier bits supply the zero extension seen by the extra unsigned digit.
  localparam int QW = WIDTH + 3;
`else
  localparam int QW = WIDTH + 1;
`endif
  localparam int            CW     = $clog2(WIDTH/2 + 2);
  localparam logic [CW-1:0] DIGITS = CW'(WIDTH/2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_d;
  logic   load, step, finish;

  logic [AW-1:0]      a_reg;
  logic [AW-1:0]      acc;
  logic [QW-1:0]      q;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      acc_sum;
  logic [AW+QW-1:0]   shifted;
  logic [2*WIDTH-1:0] result;

  // Operand extension and digit count for the accepted request.
  logic               a_ext, b_ext;
  logic [CW-1:0]      cnt_init;
`ifdef BOOTH_UNSIGNED_EN
  logic               tc_q;
  assign a_ext    = tc & a[WIDTH-1];
  assign b_ext    = tc & b[WIDTH-1];
  assign cnt_init = tc ? DIGITS : DIGITS + CW'(1);
`else
  assign a_ext    = a[WIDTH-1];
  assign b_ext    = b[WIDTH-1];
  assign cnt_init = DIGITS;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Booth digit from the low multiplier triplet; negatives are formed as one's complement plus one.
  always_comb begin
    addend = '0;
    unique case (q[2:0])
      3'b001, 3'b010: addend = a_reg;
      3'b011:         addend = a_reg << 1;
      3'b100:         addend = ~(a_reg << 1) + 1'b1;
      3'b101, 3'b110: addend = ~a_reg + 1'b1;
      default:        addend = '0;
    endcase
  end

  assign acc_sum = acc + addend;
  assign shifted = $signed({acc_sum, q}) >>> 2;

  // The product lands one bit above the bottom when the multiplier field has been fully consumed.
  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    result = tc_q ? {acc[WIDTH-1:0], q[WIDTH+2:3]}
                  : {acc[WIDTH-3:0], q[WIDTH+2:1]};
`else
    result = {acc[WIDTH-1:0], q[WIDTH:1]};
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is cleared on reset so an aborted product never leaks onto p.
    if (rst) begin
      a_reg <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      p     <= '0;
`ifdef BOOTH_UNSIGNED_EN
      tc_q  <= 1'b0;
`endif
    end else begin
      if (load) begin
        a_reg <= {{2{a_ext}}, a};
        acc   <= '0;
`ifdef BOOTH_UNSIGNED_EN
        q     <= {{2{b_ext}}, b, 1'b0};
        tc_q  <= tc;
`else
        q     <= {b, 1'b0};
`endif
        cnt   <= cnt_init;
      end else if (step) begin
        {acc, q} <= shifted;
        cnt      <= cnt - CW'(1);
      end
      done <= finish;
      if (finish) p <= result;
    end
  end

`ifndef BOOTH_UNSIGNED_EN
  // In the signed-only build the top extension bit is only used to form a_reg/q, never b_ext itself.
  logic unused_ext;
  assign unused_ext = b_ext;
`endif

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed self-checking bench for booth_r4_seq_mult (WIDTH=16); exercises the tc
// input as well when BOOTH_UNSIGNED_EN is defined.

module tb_booth_r4_seq_mult;

  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] p;
`ifdef BOOTH_UNSIGNED_EN
  logic        tc;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef BOOTH_UNSIGNED_EN
    .tc    (tc),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // Launch at the current falling edge and watch until done (bounded). When interfere is set,
  // a second request (a=2, b=2) is driven during cycles 3..5 of the operation.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input bit interfere,
                        output int lat, output int busy_cnt, output bit p_stable, output bit got);
    logic [31:0] p_hold;
    a = op_a;
    b = op_b;
    start = 1'b1;
    p_hold = p;
    lat = 0;
    busy_cnt = 0;
    p_stable = 1'b1;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (p !== p_hold) p_stable = 1'b0;
      end
      start = interfere && lat >= 3 && lat <= 5;
      if (start) begin
        a = 16'd2;
        b = 16'd2;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++;
    if (p !== 32'h0) $display("FAIL reset_p: got %h expected 00000000", p); else n_pass++;
  endtask

  task automatic test_basic;
    int lat, bc;
    bit st, got;
    run_op(16'd3, 16'd5, 1'b0, lat, bc, st, got);
    n_total++;
    if (!got || lat !== 10) $display("FAIL basic_latency: got %0d cycles (done seen=%0b) expected 10", lat, got);
    else n_pass++;
    n_total++;
    if (p !== 32'h0000000F) $display("FAIL basic_p: got %h expected 0000000f", p); else n_pass++;
    n_total++;
    if (bc !== 9) $display("FAIL basic_busy_cycles: got %0d expected 9", bc); else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: done still %b one cycle later", done); else n_pass++;
    n_total++;
    if (p !== 32'h0000000F) $display("FAIL basic_p_hold: got %h expected 0000000f", p); else n_pass++;
  endtask

  task automatic test_corners;
    logic [15:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic [15:0] tb [4] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h1234};
    logic [31:0] te [4] = '{32'h00000001, 32'hC0008000, 32'h40000000, 32'h00000000};
    int lat, bc;
    bit st, got;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run_op(ta[i], tb[i], 1'b0, lat, bc, st, got);
      n_total++;
      if (p !== te[i]) $display("FAIL corner%0d_p: %h*%h got %h expected %h", i, ta[i], tb[i], p, te[i]);
      else n_pass++;
      n_total++;
      if (!got || lat !== 10) $display("FAIL corner%0d_latency: got %0d expected 10", i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    bit st, got;
    @(negedge clk);
    run_op(16'd7, 16'd9, 1'b1, lat, bc, st, got);
    n_total++;
    if (p !== 32'h0000003F) $display("FAIL busy_start_p: got %h expected 0000003f", p); else n_pass++;
    n_total++;
    if (!got || lat !== 10) $display("FAIL busy_start_latency: got %0d expected 10", lat); else n_pass++;
    n_total++;
    if (st !== 1'b1) $display("FAIL busy_start_p_stable: p moved while busy"); else n_pass++;
    // New request on the very cycle done is high (first IDLE cycle).
    run_op(16'd2, 16'd2, 1'b0, lat, bc, st, got);
    n_total++;
    if (!got || lat !== 10) $display("FAIL b2b_latency: got %0d expected 10", lat); else n_pass++;
    n_total++;
    if (p !== 32'h00000004) $display("FAIL b2b_p: got %h expected 00000004", p); else n_pass++;
    n_total++;
    if (st !== 1'b1) $display("FAIL b2b_p_stable: p left 0000003f while busy"); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    bit st, got, seen_done;
    @(negedge clk);
    a = 16'd7;
    b = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else n_pass++;
    n_total++;
    if (p !== 32'h0) $display("FAIL midreset_p: got %h expected 00000000", p); else n_pass++;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    n_total++;
    if (seen_done !== 1'b0) $display("FAIL midreset_aborted: aborted op still produced busy/done"); else n_pass++;
    run_op(16'hFFFE, 16'd3, 1'b0, lat, bc, st, got);
    n_total++;
    if (p !== 32'hFFFFFFFA) $display("FAIL midreset_next_p: got %h expected fffffffa", p); else n_pass++;
    n_total++;
    if (!got || lat !== 10) $display("FAIL midreset_next_latency: got %0d expected 10", lat); else n_pass++;
  endtask

`ifdef BOOTH_UNSIGNED_EN
  task automatic test_unsigned;
    int lat, bc;
    bit st, got;
    @(negedge clk);
    tc = 1'b0;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bc, st, got);
    n_total++;
    if (p !== 32'hFFFE0001) $display("FAIL unsigned_p: got %h expected fffe0001", p); else n_pass++;
    n_total++;
    if (!got || lat !== 11) $display("FAIL unsigned_latency: got %0d expected 11", lat); else n_pass++;
    @(negedge clk);
    tc = 1'b1;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bc, st, got);
    n_total++;
    if (p !== 32'h00000001) $display("FAIL signed_tc_p: got %h expected 00000001", p); else n_pass++;
    n_total++;
    if (!got || lat !== 10) $display("FAIL signed_tc_latency: got %0d expected 10", lat); else n_pass++;
  endtask
`endif

  initial begin
`ifdef BOOTH_UNSIGNED_EN
    tc = 1'b1;
`endif
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
`ifdef BOOTH_UNSIGNED_EN
    test_unsigned();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
